// File: rtl/hpdcache_rr_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hpdcache_rr_req_scheduler
// Purpose  : Round-robin scheduler sharing one downstream request port among
//            N requesters. The winner is granted combinationally in the same
//            cycle it is selected. Its binary index steers the datapath mux.
//            The grant is held while the downstream port stalls. The fairness
//            pointer moves only when a transfer is accepted.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N       number of requesters (N >= 1)
//   N_LOG2  width of the index output, derived from N
// Ports
//   clk_i         in   1       clock, rising edge
//   rst_ni        in   1       asynchronous reset, active low
//   req_valid_i   in   N       per-requester request valid
//   req_ready_o   out  N       per-requester accept (one-hot or zero)
//   gnt_valid_o   out  1       downstream request valid
//   gnt_ready_i   in   1       downstream accept
//   gnt_idx_o     out  N_LOG2  binary index of the granted requester
//   gnt_onehot_o  out  N       one-hot form of gnt_idx_o, zero when idle
// ============================================================================
module hpdcache_rr_req_scheduler #(
    parameter int N = 4,
    localparam int N_LOG2 = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N-1:0]      req_valid_i,
    output logic [N-1:0]      req_ready_o,
    output logic              gnt_valid_o,
    input  logic              gnt_ready_i,
    output logic [N_LOG2-1:0] gnt_idx_o,
    output logic [N-1:0]      gnt_onehot_o
);

    localparam logic [N_LOG2-1:0] c_LAST_IDX = N_LOG2'(N - 1);

    // Architectural state
    logic [N_LOG2-1:0] r_ptr;     // first index considered in the next round
    logic              r_lock;    // a stalled grant is being held
    logic [N_LOG2-1:0] r_lidx;    // index of the held grant

    // Combinational arbitration
    logic [N-1:0]      w_mask;
    logic [N-1:0]      w_masked;
    logic              w_any;
    logic              w_any_masked;
    logic [N_LOG2-1:0] w_idx_masked;
    logic [N_LOG2-1:0] w_idx_any;
    logic [N_LOG2-1:0] w_idx;
    logic              w_gnt_valid;
    logic [N-1:0]      w_onehot;
    logic              w_xfer;
    logic [N_LOG2-1:0] w_ptr_next;

    // Requesters at or above the pointer are eligible first; this is the
    // ~((1 << ptr) - 1) mask, built bitwise so it works for any N.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (N_LOG2'(i) >= r_ptr);
        end
    end

    assign w_masked     = req_valid_i & w_mask;
    assign w_any        = |req_valid_i;
    assign w_any_masked = |w_masked;

    // Lowest set bit of each vector. Scanning downwards lets the last
    // assignment (lowest index) win without needing an early exit.
    always_comb begin
        w_idx_masked = '0;
        w_idx_any    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_idx_masked = N_LOG2'(i);
            end
            if (req_valid_i[i]) begin
                w_idx_any = N_LOG2'(i);
            end
        end
    end

    // A held grant overrides fresh arbitration. With no request at all the
    // fallback encoder yields 0, which keeps the index output at 0 when idle.
    always_comb begin
        if (r_lock) begin
            w_idx = r_lidx;
        end else if (w_any_masked) begin
            w_idx = w_idx_masked;
        end else begin
            w_idx = w_idx_any;
        end
    end

    assign w_gnt_valid = r_lock | w_any;

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < N; i++) begin
            w_onehot[i] = w_gnt_valid && (w_idx == N_LOG2'(i));
        end
    end

    assign w_xfer     = w_gnt_valid & gnt_ready_i;
    assign w_ptr_next = (w_idx == c_LAST_IDX) ? '0 : (w_idx + N_LOG2'(1));

    assign gnt_valid_o  = w_gnt_valid;
    assign gnt_idx_o    = w_idx;
    assign gnt_onehot_o = w_onehot;
    assign req_ready_o  = w_onehot & {N{gnt_ready_i}};

    // On an accepted transfer the pointer moves just past the winner and any
    // lock is released. A stalled grant is latched so that later arrivals at
    // lower indices cannot pre-empt it; the pointer is left untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr  <= '0;
            r_lock <= 1'b0;
            r_lidx <= '0;
        end else if (w_xfer) begin
            r_ptr  <= w_ptr_next;
            r_lock <= 1'b0;
        end else if (w_gnt_valid) begin
            r_lock <= 1'b1;
            r_lidx <= w_idx;
        end
    end

`ifndef SYNTHESIS
    // A requester owning a held grant must keep its valid asserted.
    a_hold_while_locked : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        r_lock |-> req_valid_i[r_lidx]
    );

    a_ready_onehot : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        $onehot0(req_ready_o)
    );
`endif

endmodule
`default_nettype wire
